// File: rtl/rev_dpg_uncompute_pkg.sv
// Shared definitions for the DPG uncompute engine: FSM encoding,
// default operand width and the counter-width helper.
package rev_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-index counter width for a given operand width (WIDTH >= 2).
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/rev_dpg_uncompute_if.sv
// Record-in / result-out bus of the DPG uncompute engine.
// master = producer/consumer side, slave = engine side.
interface rev_dpg_uncompute_if
    import rev_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = cnt_w(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] s_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             cin_out;
    logic             err;
    logic [CNT_W-1:0] err_bit;

    modport master (
        output in_valid, p_in, q_in, r_in, s_in, out_ready,
        input  in_ready, out_valid, a_out, b_out, cin_out, err, err_bit
    );

    modport slave (
        input  in_valid, p_in, q_in, r_in, s_in, out_ready,
        output in_ready, out_valid, a_out, b_out, cin_out, err, err_bit
    );
endinterface

// File: rtl/rev_dpg_uncompute_inv_bit.sv
// Combinational inverse of one DPG gate: from (p,q,r,s) recover operand
// bits a, b, the incoming carry c, and the residual ancilla d (0 when the
// gate output is consistent).
module dpg_inv_bit (
    input  logic p,
    input  logic q,
    input  logic r,
    input  logic s,
    output logic a,
    output logic b,
    output logic c,
    output logic d
);
    // q = a^b, r = a^b^c, s = maj(a,b,c) = (a&b) ^ (c&(a^b))
    always_comb begin
        a = p;
        b = p ^ q;
        c = q ^ r;
        d = s ^ ((q & c) ^ (a & b));
    end
endmodule

// File: rtl/rev_dpg_uncompute.sv
// Bit-serial uncompute engine for a WIDTH-bit DPG ripple-carry adder.
// Walks the latched P/Q/R/S words LSB first, one bit per cycle, rebuilding
// A, B and carry-in and flagging the first ancilla / carry-chain violation.
// Optional build macro: REV_UNCOMP_EARLY_ABORT_EN (stop at first violation).
module rev_dpg_uncompute
    import rev_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    rev_dpg_uncompute_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] p_r, q_r, r_r, s_r;
    logic [CNT_W-1:0] cnt;
    logic             s_prev;
    logic [WIDTH-1:0] a_r, b_r;
    logic             cin_r;
    logic             err_r;
    logic [CNT_W-1:0] err_bit_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic bit_a, bit_b, bit_c, bit_d;
    logic viol;

    dpg_inv_bit u_inv (
        .p (p_r[cnt]),
        .q (q_r[cnt]),
        .r (r_r[cnt]),
        .s (s_r[cnt]),
        .a (bit_a),
        .b (bit_b),
        .c (bit_c),
        .d (bit_d)
    );

    // Bit 0 has no predecessor, so only the ancilla term applies there.
    always_comb begin
        viol = bit_d | ((cnt != '0) & (bit_c != s_prev));
    end

    // IDLE/RUN/DONE sequencer with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            p_r         <= '0;
            q_r         <= '0;
            r_r         <= '0;
            s_r         <= '0;
            cnt         <= '0;
            s_prev      <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            cin_r       <= 1'b0;
            err_r       <= 1'b0;
            err_bit_r   <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        p_r        <= bus.p_in;
                        q_r        <= bus.q_in;
                        r_r        <= bus.r_in;
                        s_r        <= bus.s_in;
                        a_r        <= '0;
                        b_r        <= '0;
                        cin_r      <= 1'b0;
                        err_r      <= 1'b0;
                        err_bit_r  <= '0;
                        cnt        <= '0;
                        s_prev     <= 1'b0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_r[cnt] <= bit_a;
                    b_r[cnt] <= bit_b;
                    if (cnt == '0)
                        cin_r <= bit_c;
                    s_prev <= s_r[cnt];
                    if (viol && !err_r) begin
                        err_r     <= 1'b1;
                        err_bit_r <= cnt;
                    end
`ifdef REV_UNCOMP_EARLY_ABORT_EN
                    if ((viol && !err_r) || cnt == LAST)
                        state <= DONE;
                    else
                        cnt <= cnt + 1'b1;
`else
                    if (cnt == LAST)
                        state <= DONE;
                    else
                        cnt <= cnt + 1'b1;
`endif
                end
                DONE: begin
                    // First DONE cycle raises out_valid; then wait for accept.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.a_out     = a_r;
    assign bus.b_out     = b_r;
    assign bus.cin_out   = cin_r;
    assign bus.err       = err_r;
    assign bus.err_bit   = err_bit_r;

endmodule
